// File: rtl/round_referee.sv
// Referee for an N-player lightbike round: tracks surviving bikes, flags the winner or a draw,
// and keeps a saturating win tally per player. Every output is a register.
module round_referee #(
   parameter int NUM_PLAYERS = 4,
   parameter int ID_W        = 2,
   parameter int WIN_W       = 4
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [NUM_PLAYERS-1:0]       active_mask,
   input  logic                         frame_tick,
   input  logic [NUM_PLAYERS-1:0]       crash,
   output logic                         in_play,
   output logic                         game_finished,
   output logic                         round_end,
   output logic [NUM_PLAYERS-1:0]       alive_mask,
   output logic                         winner_valid,
   output logic [ID_W-1:0]              winner_id,
   output logic                         draw,
   output logic [NUM_PLAYERS*WIN_W-1:0] win_count
);

   localparam int CNT_W = $clog2(NUM_PLAYERS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PLAYERS-1:0] m);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_PLAYERS; i++)
         c = c + CNT_W'(m[i]);
      return c;
   endfunction

   function automatic logic [ID_W-1:0] first_index(input logic [NUM_PLAYERS-1:0] m);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--)
         if (m[i]) idx = ID_W'(i);
      return idx;
   endfunction

   function automatic logic [WIN_W-1:0] sat_inc(input logic [WIN_W-1:0] c);
      if (c == {WIN_W{1'b1}})
         return c;
      return c + WIN_W'(1);
   endfunction

   logic [NUM_PLAYERS-1:0] next_alive;
   logic [CNT_W-1:0]       next_cnt;
   logic                   start_ok;

   always_comb begin
      next_alive = alive_mask & ~crash;
      next_cnt   = popcount(next_alive);
      start_ok   = start && (popcount(active_mask) >= CNT_W'(2));
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         in_play       <= 1'b0;
         game_finished <= 1'b0;
         round_end     <= 1'b0;
         alive_mask    <= '0;
         winner_valid  <= 1'b0;
         winner_id     <= '0;
         draw          <= 1'b0;
         win_count     <= '0;
      end else begin
         round_end <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  state         <= PLAY;
                  in_play       <= 1'b1;
                  game_finished <= 1'b0;
                  alive_mask    <= active_mask;
                  winner_valid  <= 1'b0;
                  winner_id     <= '0;
                  draw          <= 1'b0;
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  alive_mask <= next_alive;
                  // Round ends when fewer than two bikes survive this tick
                  if (next_cnt < CNT_W'(2)) begin
                     state         <= DONE;
                     in_play       <= 1'b0;
                     game_finished <= 1'b1;
                     round_end     <= 1'b1;
                     if (next_cnt == CNT_W'(1)) begin
                        winner_valid <= 1'b1;
                        winner_id    <= first_index(next_alive);
                        for (int i = 0; i < NUM_PLAYERS; i++)
                           if (next_alive[i])
                              win_count[i*WIN_W +: WIN_W] <= sat_inc(win_count[i*WIN_W +: WIN_W]);
                     end else begin
                        draw <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state         <= IDLE;
               in_play       <= 1'b0;
               game_finished <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee: table of single-cycle vectors plus hand-written
// sequences for rejected start, win-counter saturation and asynchronous reset mid-round.
module tb_round_referee;

   localparam int NP = 4;
   localparam int IW = 2;
   localparam int WW = 2;

   logic          clock = 1'b0;
   logic          resetn;
   logic          start;
   logic [NP-1:0] active_mask;
   logic          frame_tick;
   logic [NP-1:0] crash;
   logic          in_play, game_finished, round_end, winner_valid, draw;
   logic [NP-1:0] alive_mask;
   logic [IW-1:0] winner_id;
   logic [NP*WW-1:0] win_count;

   int n_checks = 0;
   int n_fail   = 0;

   round_referee #(.NUM_PLAYERS(NP), .ID_W(IW), .WIN_W(WW)) dut (
      .clock(clock), .resetn(resetn), .start(start), .active_mask(active_mask),
      .frame_tick(frame_tick), .crash(crash), .in_play(in_play),
      .game_finished(game_finished), .round_end(round_end), .alive_mask(alive_mask),
      .winner_valid(winner_valid), .winner_id(winner_id), .draw(draw),
      .win_count(win_count)
   );

   always #5 clock = ~clock;

   // {in_play, game_finished, round_end, alive[4], winner_valid, winner_id[2], draw, win_count[8]}
   function automatic logic [18:0] pk(input logic ip, input logic gf, input logic re,
                                      input logic [3:0] al, input logic wv,
                                      input logic [1:0] wid, input logic dr,
                                      input logic [7:0] wc);
      return {ip, gf, re, al, wv, wid, dr, wc};
   endfunction

   function automatic logic [18:0] outs();
      return pk(in_play, game_finished, round_end, alive_mask, winner_valid,
                winner_id, draw, win_count);
   endfunction

   task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %05h expected %05h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [3:0] m, input logic t, input logic [3:0] c);
      start = s; active_mask = m; frame_tick = t; crash = c;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   typedef struct packed {
      logic        s;
      logic [3:0]  m;
      logic        t;
      logic [3:0]  c;
      logic [18:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // Round 1: 4 players, bikes 1, 3, 0 crash; player 2 wins (win_count bits [5:4]).
      tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, pk(1,0,0,4'b1111,0,2'd0,0,8'h00)};
      tbl[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, pk(1,0,0,4'b1101,0,2'd0,0,8'h00)};
      tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b1111, pk(1,0,0,4'b1101,0,2'd0,0,8'h00)};
      tbl[3]  = '{1'b1, 4'b0011, 1'b0, 4'b0000, pk(1,0,0,4'b1101,0,2'd0,0,8'h00)};
      tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b1000, pk(1,0,0,4'b0101,0,2'd0,0,8'h00)};
      tbl[5]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, pk(1,0,0,4'b0101,0,2'd0,0,8'h00)};
      tbl[6]  = '{1'b0, 4'b0000, 1'b1, 4'b0001, pk(0,1,1,4'b0100,1,2'd2,0,8'h10)};
      tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, pk(0,1,0,4'b0100,1,2'd2,0,8'h10)};
      tbl[8]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, pk(0,1,0,4'b0100,1,2'd2,0,8'h10)};
      // Round 2: two players crash together -> draw, tally unchanged.
      tbl[9]  = '{1'b1, 4'b0011, 1'b0, 4'b0000, pk(1,0,0,4'b0011,0,2'd0,0,8'h10)};
      tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b0011, pk(0,1,1,4'b0000,0,2'd0,1,8'h10)};
      tbl[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, pk(0,1,0,4'b0000,0,2'd0,1,8'h10)};

      resetn = 1'b0;
      drive(1'b0, 4'b0000, 1'b0, 4'b0000);
      step();
      step();
      chk("reset_state", outs(), '0);
      resetn = 1'b1;
      step();
      chk("idle_after_reset", outs(), '0);

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].s, tbl[i].m, tbl[i].t, tbl[i].c);
         step();
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end
      drive(1'b0, 4'b0000, 1'b0, 4'b0000);

      // Reset, then a single-player start from IDLE must be rejected.
      #2 resetn = 1'b0;
      #1 chk("reset_from_done", outs(), '0);
      step();
      resetn = 1'b1;
      drive(1'b1, 4'b0100, 1'b0, 4'b0000);
      step();
      chk("reject_start_idle", outs(), '0);
      drive(1'b0, 4'b0000, 1'b0, 4'b0000);
      step();
      chk("still_idle", outs(), '0);

      // Player 1 wins four rounds in a row; its 2-bit tally sticks at 3.
      for (int r = 1; r <= 4; r++) begin
         drive(1'b1, 4'b0011, 1'b0, 4'b0000);
         step();
         drive(1'b0, 4'b0000, 1'b1, 4'b0001);
         step();
         chk($sformatf("sat_round%0d", r), outs(),
             pk(0,1,1,4'b0010,1,2'd1,0,8'((r > 3 ? 3 : r) << 2)));
         drive(1'b0, 4'b0000, 1'b0, 4'b0000);
      end

      // Async reset mid-PLAY with a nonzero tally: everything clears before the next edge.
      drive(1'b1, 4'b1111, 1'b0, 4'b0000);
      step();
      drive(1'b0, 4'b0000, 1'b1, 4'b0001);
      step();
      chk("midplay_before_reset", outs(), pk(1,0,0,4'b1110,0,2'd0,0,8'h0C));
      drive(1'b0, 4'b0000, 1'b1, 4'b1100);
      #2 resetn = 1'b0;
      #1 chk("async_reset_immediate", outs(), '0);
      step();
      chk("reset_held", outs(), '0);
      resetn = 1'b1;
      drive(1'b0, 4'b0000, 1'b0, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("no_round_end_after_reset%0d", k), outs(), '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
